// File: rtl/period_meter_pkg.sv
// Shared constants and FSM encoding for the period meter.
package period_meter_pkg;

  localparam int CLK_HZ = 12_000_000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_MEAS  = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARM   = ST_ARM,
    MEAS  = ST_MEAS,
    STALL = ST_STALL
  } state_t;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Synchronizes the async input and detects its rising edge in the clk domain.
// ready marks the point where s first reflects the pin rather than reset zeros.
module period_meter_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic ready
);

  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] prime;
  logic              s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= '0;
      prime  <= '0;
      s_prev <= 1'b0;
    end else begin
      chain  <= {chain[STAGES-2:0], sig_in};
      prime  <= {prime[STAGES-2:0], 1'b1};
      s_prev <= chain[STAGES-1];
    end
  end

  assign s     = chain[STAGES-1];
  assign rise  = s & ~s_prev;
  assign ready = prime[STAGES-1];

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of sig_in in clk cycles; strobes valid per period.
// Flags stalled after TIMEOUT cycles with no rising edge.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int               CNT_W       = 25,
  parameter logic [CNT_W-1:0] TIMEOUT     = 25'd24000000,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] TMO_LAST = TIMEOUT - CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic             s;
  logic             rise_raw;
  logic             ready;
  logic             rise;
  logic             timeout;
  logic             meas_done;
  logic             enter_stall;

  period_meter_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .s      (s),
    .rise   (rise_raw),
    .ready  (ready)
  );

  // Edges seen in IDLE are ignored so a pin already high at reset never counts.
  assign rise    = rise_raw & (state != IDLE);
  assign timeout = (cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    meas_done   = 1'b0;
    enter_stall = 1'b0;
    case (state)
      IDLE: begin
        if (timeout)             state_nxt = STALL;
        else if (ready && !s)    state_nxt = ARM;
      end
      ARM: begin
        if (rise)                state_nxt = MEAS;
        else if (timeout)        state_nxt = STALL;
      end
      MEAS: begin
        if (rise)                meas_done = 1'b1;
        else if (timeout)        state_nxt = STALL;
      end
      STALL: begin
        if (rise)                state_nxt = MEAS;
      end
      default:                   state_nxt = IDLE;
    endcase
    enter_stall = (state != STALL) && (state_nxt == STALL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      if (rise)                 cnt <= '0;
      else if (state != STALL)  cnt <= cnt + CNT_W'(1);

      if (rise)                       hcnt <= CNT_W'(1);
      else if ((state == MEAS) && s)  hcnt <= hcnt + CNT_W'(1);
    end
  end

  // The rise cycle itself is the last cycle of the period, hence cnt+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      valid <= meas_done;
      if (meas_done) begin
        period    <= cnt + CNT_W'(1);
        high_time <= hcnt;
      end else if (enter_stall) begin
        period    <= '0;
        high_time <= '0;
      end
      if (enter_stall)                     stalled <= 1'b1;
      else if ((state == STALL) && rise)   stalled <= 1'b0;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Randomized and directed bench for period_meter against a history-based reference model.
module tb_period_meter;

  localparam int SYNC = 2;
  localparam int TMO  = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig_in;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       valid;
  logic       stalled;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;
  bit started  = 1'b0;

  period_meter #(.CNT_W(8), .TIMEOUT(8'd100), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .stalled   (stalled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin samples per edge, synchronized value is the sample
  // SYNC-1 edges back; period/high come straight from that history.
  typedef enum {M_IDLE, M_ARM, M_MEAS, M_STALL} mphase_t;
  bit         samp [0:65535];
  int         ecount, ref_c, last_rise, c, hsum;
  bit         sc, sp, er;
  mphase_t    mph;
  logic [7:0] m_period, m_high;
  bit         m_valid, m_stalled;

  function automatic bit s_at(input int cyc);
    return (cyc >= SYNC) ? samp[cyc-SYNC+1] : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecount = 0; ref_c = -1; last_rise = 0; mph = M_IDLE;
      m_period = 0; m_high = 0; m_valid = 0; m_stalled = 0;
    end else begin
      c  = ecount;
      sc = s_at(c);
      sp = (c > 0) ? s_at(c-1) : 1'b0;
      er = sc && !sp && (mph != M_IDLE);
      m_valid = 0;
      if (er) begin
        if (mph == M_MEAS) begin
          hsum = 0;
          for (int k = last_rise; k < c; k++) hsum += int'(s_at(k));
          m_period = 8'(c - last_rise);
          m_high   = 8'(hsum);
          m_valid  = 1;
        end
        if (mph == M_STALL) m_stalled = 0;
        mph = M_MEAS; last_rise = c; ref_c = c;
      end else if (mph != M_STALL && (c - ref_c) == TMO) begin
        mph = M_STALL; m_stalled = 1; m_period = 0; m_high = 0;
      end else if (mph == M_IDLE && c >= SYNC && !sc) begin
        mph = M_ARM;
      end
      samp[c+1] = sig_in;
      ecount = c + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && started) begin
      chk("period", 32'(period), 32'(m_period));
      chk("high_time", 32'(high_time), 32'(m_high));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("stalled", 32'(stalled), 32'(m_stalled));
      if (valid) vcount++;
    end
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      sig_in = v;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    rst_n  = 1'b0;
    sig_in = v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic async_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_period", 32'(period), 32'd0);
    chk("async_high", 32'(high_time), 32'd0);
    chk("async_valid", 32'(valid), 32'd0);
    chk("async_stalled", 32'(stalled), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hi, lo;
    rst_n  = 1'b1;
    sig_in = 1'b1;
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_period", 32'(period), 32'd0);
    chk("reset_high", 32'(high_time), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_stalled", 32'(stalled), 32'd0);
    started = 1'b1;

    // Pin high through reset: no edge, stall exactly TMO cycles after release.
    do_reset(1'b1);
    vcount = 0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("hi_at_reset_stall_99", 32'(stalled), 32'd0);
    @(negedge clk);
    chk("hi_at_reset_stall_100", 32'(stalled), 32'd1);
    chk("hi_at_reset_period", 32'(period), 32'd0);
    chk("hi_at_reset_no_valid", 32'(vcount), 32'd0);

    do_reset(1'b0);
    drive(1'b0, 5);
    vcount = 0;
    wave(5, 5, 4);
    chk("sq55_period", 32'(period), 32'd10);
    chk("sq55_high", 32'(high_time), 32'd5);
    chk("sq55_valids", 32'(vcount), 32'd3);

    wave(3, 4, 4);
    chk("w34_period", 32'(period), 32'd7);
    chk("w34_high", 32'(high_time), 32'd3);
    wave(1, 1, 6);
    chk("toggle_period", 32'(period), 32'd2);
    chk("toggle_high", 32'(high_time), 32'd1);

    drive(1'b0, 120);
    chk("stop_stalled", 32'(stalled), 32'd1);
    chk("stop_period", 32'(period), 32'd0);
    chk("stop_high", 32'(high_time), 32'd0);

    vcount = 0;
    wave(5, 5, 3);
    chk("resume_valids", 32'(vcount), 32'd2);
    chk("resume_stalled", 32'(stalled), 32'd0);
    chk("resume_period", 32'(period), 32'd10);

    // Rise lands on the last pre-timeout count: must measure, not stall.
    wave(10, 90, 2);
    drive(1'b1, 10);
    chk("coincide_period", 32'(period), 32'd100);
    chk("coincide_high", 32'(high_time), 32'd10);
    chk("coincide_stalled", 32'(stalled), 32'd0);
    drive(1'b0, 3);

    async_pulse();
    vcount = 0;
    drive(1'b0, 4);
    wave(4, 6, 3);
    chk("restart_valids", 32'(vcount), 32'd2);
    chk("restart_period", 32'(period), 32'd10);
    chk("restart_high", 32'(high_time), 32'd4);

    for (int i = 0; i < 80; i++) begin
      hi = $urandom_range(1, 12);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(90, 112) : $urandom_range(1, 12);
      wave(hi, lo, 1);
      if (i == 40) async_pulse();
    end
    drive(1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
